// File: rtl/dtg_pkg.sv
// Shared timing constant sets and helpers for the display timing generator.
package dtg_pkg;

    // One complete raster geometry: porches and sync widths in pixels/lines.
    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        logic        hs_pol;
        logic        vs_pol;
    } dtg_timing_t;

    // Flags carried through the sync-alignment pipeline.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
        logic hblank;
        logic vblank;
    } dtg_flags_t;

    localparam dtg_timing_t DTG_640X480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
        hs_pol: 1'b0,  vs_pol: 1'b0
    };

    localparam dtg_timing_t DTG_800X600_72 = '{
        h_active: 800, h_fp: 56, h_sync: 120, h_bp: 64,
        v_active: 600, v_fp: 37, v_sync: 6,   v_bp: 23,
        hs_pol: 1'b1,  vs_pol: 1'b1
    };

    localparam int unsigned DTG_MAX_SYNC_DLY = 8;

    // Bits needed to represent values 0..v-1.
    function automatic int unsigned dtg_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if (v > (32'd1 << i)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dtg_delay.sv
// Generic enabled shift register; every stage loads RST_VAL on reset.
module dtg_delay #(
    parameter int unsigned     WIDTH   = 1,
    parameter int unsigned     DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Flush on reset, otherwise shift one stage per enabled cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
        end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dtg_param.sv
// Parametrised display timing generator: raster counters, sync/blank flags
// aligned to a downstream pipeline, line/frame strobes and a frame counter.
module dtg_param
    import dtg_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DTG_640X480_60.h_active,
    parameter int unsigned H_FP     = DTG_640X480_60.h_fp,
    parameter int unsigned H_SYNC   = DTG_640X480_60.h_sync,
    parameter int unsigned H_BP     = DTG_640X480_60.h_bp,
    parameter int unsigned V_ACTIVE = DTG_640X480_60.v_active,
    parameter int unsigned V_FP     = DTG_640X480_60.v_fp,
    parameter int unsigned V_SYNC   = DTG_640X480_60.v_sync,
    parameter int unsigned V_BP     = DTG_640X480_60.v_bp,
    parameter bit          HS_POL   = DTG_640X480_60.hs_pol,
    parameter bit          VS_POL   = DTG_640X480_60.vs_pol,
    parameter int unsigned CW       = 11,
    parameter int unsigned SYNC_DLY = 1
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          pix_en,
    output logic [CW-1:0] pixel_column,
    output logic [CW-1:0] pixel_row,
    output logic          horiz_sync,
    output logic          vert_sync,
    output logic          video_on,
    output logic          hblank,
    output logic          vblank,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_count
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam dtg_flags_t FLAGS_RST = '{
        hsync: !HS_POL, vsync: !VS_POL, video_on: 1'b0, hblank: 1'b0, vblank: 1'b0
    };

    // Reject degenerate geometry and undersized counters at elaboration.
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        SYNC_DLY < 1 || SYNC_DLY > DTG_MAX_SYNC_DLY) begin : g_bad_geometry
        $error("dtg_param: zero porch/sync width or SYNC_DLY outside 1..8");
    end
    if (CW < dtg_clog2(H_TOTAL) || CW < dtg_clog2(V_TOTAL)) begin : g_bad_cw
        $error("dtg_param: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
    end

    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [7:0]    fc_q, fc_d;
    dtg_flags_t    flags_raw, flags_dly;

    // Raster advance: column every enabled cycle, row on column wrap, frame on row wrap.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        fc_d  = fc_q;
        if (pix_en) begin
            if (col_q == H_LAST) begin
                col_d = '0;
                if (row_q == V_LAST) begin
                    row_d = '0;
                    fc_d  = fc_q + 8'd1;
                end else begin
                    row_d = row_q + CW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Counter registers; hold automatically when pix_en is low.
    always_ff @(posedge clock) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            fc_q  <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            fc_q  <= fc_d;
        end
    end

    // Region decode from the undelayed counters.
    always_comb begin
        flags_raw          = FLAGS_RST;
        flags_raw.hsync    = (col_q >= HS_FIRST && col_q <= HS_LAST) ? HS_POL : !HS_POL;
        flags_raw.vsync    = (row_q >= VS_FIRST && row_q <= VS_LAST) ? VS_POL : !VS_POL;
        flags_raw.video_on = (col_q < H_ACT_C) && (row_q < V_ACT_C);
        flags_raw.hblank   = (col_q >= H_ACT_C);
        flags_raw.vblank   = (row_q >= V_ACT_C);
    end

    dtg_delay #(
        .WIDTH   ($bits(dtg_flags_t)),
        .DEPTH   (SYNC_DLY),
        .RST_VAL (FLAGS_RST)
    ) u_flag_dly (
        .clk_i (clock),
        .rst_i (rst),
        .en_i  (pix_en),
        .d_i   (flags_raw),
        .q_o   (flags_dly)
    );

    assign pixel_column = col_q;
    assign pixel_row    = row_q;
    assign frame_count  = fc_q;
    assign horiz_sync   = flags_dly.hsync;
    assign vert_sync    = flags_dly.vsync;
    assign video_on     = flags_dly.video_on;
    assign hblank       = flags_dly.hblank;
    assign vblank       = flags_dly.vblank;
    assign line_start   = pix_en && (col_q == '0) && !rst;
    assign frame_start  = line_start && (row_q == '0);

endmodule

// File: tb/tb_dtg_param.sv
// Bench for dtg_param: four instances with different geometry, polarity,
// delay and pixel-enable patterns, each compared every clock against a
// model that derives all outputs from the count of enabled cycles since reset.
module tb_dtg_param;

    typedef struct packed {
        int unsigned ha, hf, hs, hb, va, vf, vs, vb, dly;
        logic        hpol, vpol;
    } geom_t;

    // Instance 0 uses the module defaults; G0 restates them from the datasheet.
    localparam geom_t G0 = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0, 1'b0};
    localparam geom_t G1 = '{ 20,  2,  3,  3,  12,  2, 2,  2, 3, 1'b1, 1'b1};
    localparam geom_t G2 = '{  4,  1,  2,  1,   3,  1, 1,  1, 1, 1'b0, 1'b0};
    localparam geom_t G3 = '{ 10,  1,  1,  1,   5,  1, 1,  1, 8, 1'b1, 1'b0};

    logic        clock = 1'b0;
    logic        rst;
    logic        en  [4];
    logic [10:0] col [4];
    logic [10:0] row [4];
    logic [7:0]  fc  [4];
    logic        hs  [4];
    logic        vs  [4];
    logic        vo  [4];
    logic        hb  [4];
    logic        vb  [4];
    logic        ls  [4];
    logic        fs  [4];

    int unsigned n [4];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cyc = 0;
    bit          armed = 1'b0;

    always #5 clock = ~clock;

    dtg_param u_dut0 (
        .clock(clock), .rst(rst), .pix_en(en[0]),
        .pixel_column(col[0]), .pixel_row(row[0]),
        .horiz_sync(hs[0]), .vert_sync(vs[0]), .video_on(vo[0]),
        .hblank(hb[0]), .vblank(vb[0]),
        .line_start(ls[0]), .frame_start(fs[0]), .frame_count(fc[0])
    );

    dtg_param #(
        .H_ACTIVE(G1.ha), .H_FP(G1.hf), .H_SYNC(G1.hs), .H_BP(G1.hb),
        .V_ACTIVE(G1.va), .V_FP(G1.vf), .V_SYNC(G1.vs), .V_BP(G1.vb),
        .HS_POL(G1.hpol), .VS_POL(G1.vpol), .CW(11), .SYNC_DLY(G1.dly)
    ) u_dut1 (
        .clock(clock), .rst(rst), .pix_en(en[1]),
        .pixel_column(col[1]), .pixel_row(row[1]),
        .horiz_sync(hs[1]), .vert_sync(vs[1]), .video_on(vo[1]),
        .hblank(hb[1]), .vblank(vb[1]),
        .line_start(ls[1]), .frame_start(fs[1]), .frame_count(fc[1])
    );

    dtg_param #(
        .H_ACTIVE(G2.ha), .H_FP(G2.hf), .H_SYNC(G2.hs), .H_BP(G2.hb),
        .V_ACTIVE(G2.va), .V_FP(G2.vf), .V_SYNC(G2.vs), .V_BP(G2.vb),
        .HS_POL(G2.hpol), .VS_POL(G2.vpol), .CW(11), .SYNC_DLY(G2.dly)
    ) u_dut2 (
        .clock(clock), .rst(rst), .pix_en(en[2]),
        .pixel_column(col[2]), .pixel_row(row[2]),
        .horiz_sync(hs[2]), .vert_sync(vs[2]), .video_on(vo[2]),
        .hblank(hb[2]), .vblank(vb[2]),
        .line_start(ls[2]), .frame_start(fs[2]), .frame_count(fc[2])
    );

    dtg_param #(
        .H_ACTIVE(G3.ha), .H_FP(G3.hf), .H_SYNC(G3.hs), .H_BP(G3.hb),
        .V_ACTIVE(G3.va), .V_FP(G3.vf), .V_SYNC(G3.vs), .V_BP(G3.vb),
        .HS_POL(G3.hpol), .VS_POL(G3.vpol), .CW(11), .SYNC_DLY(G3.dly)
    ) u_dut3 (
        .clock(clock), .rst(rst), .pix_en(en[3]),
        .pixel_column(col[3]), .pixel_row(row[3]),
        .horiz_sync(hs[3]), .vert_sync(vs[3]), .video_on(vo[3]),
        .hblank(hb[3]), .vblank(vb[3]),
        .line_start(ls[3]), .frame_start(fs[3]), .frame_count(fc[3])
    );

    function automatic geom_t geo(input int i);
        case (i)
            0:       return G0;
            1:       return G1;
            2:       return G2;
            default: return G3;
        endcase
    endfunction

    // Expected {col,row,frame_count,hs,vs,video_on,hblank,vblank,line_start,frame_start}
    // after n enabled cycles since reset, with the current pix_en/rst levels.
    function automatic logic [36:0] model(input geom_t g, input int unsigned n,
                                          input logic e, input logic r);
        int unsigned ht, vt, c, rw, f, m, c2, r2;
        logic [4:0]  fl;
        logic        l, fsx;
        ht = g.ha + g.hf + g.hs + g.hb;
        vt = g.va + g.vf + g.vs + g.vb;
        c  = n % ht;
        rw = (n / ht) % vt;
        f  = (n / (ht * vt)) % 256;
        if (n >= g.dly) begin
            m  = n - g.dly;
            c2 = m % ht;
            r2 = (m / ht) % vt;
            fl[4] = (c2 >= g.ha + g.hf && c2 < g.ha + g.hf + g.hs) ? g.hpol : !g.hpol;
            fl[3] = (r2 >= g.va + g.vf && r2 < g.va + g.vf + g.vs) ? g.vpol : !g.vpol;
            fl[2] = (c2 < g.ha) && (r2 < g.va);
            fl[1] = (c2 >= g.ha);
            fl[0] = (r2 >= g.va);
        end else begin
            fl = {!g.hpol, !g.vpol, 3'b000};
        end
        l   = e && !r && (c == 0);
        fsx = l && (rw == 0);
        return {11'(c), 11'(rw), 8'(f), fl, l, fsx};
    endfunction

    task automatic run(input int unsigned ncyc, input logic rst_v);
        logic [36:0] obs, exp;
        for (int unsigned k = 0; k < ncyc; k++) begin
            @(negedge clock);
            rst   = rst_v;
            en[0] = 1'b1;
            en[1] = (cyc % 4 == 0);
            en[2] = 1'($urandom_range(0, 1));
            en[3] = ($urandom_range(0, 3) != 0);
            #1;
            if (armed) begin
                for (int i = 0; i < 4; i++) begin
                    obs = {col[i], row[i], fc[i], hs[i], vs[i], vo[i], hb[i], vb[i], ls[i], fs[i]};
                    exp = model(geo(i), n[i], en[i], rst_v);
                    vectors++;
                    assert (obs === exp) else begin
                        miscompares++;
                        $error("FAIL dut%0d cyc=%0d observed=%h expected=%h", i, cyc, obs, exp);
                    end
                end
            end
            @(posedge clock);
            for (int i = 0; i < 4; i++) begin
                if (rst_v) n[i] = 0;
                else if (en[i]) n[i] = n[i] + 1;
            end
            if (rst_v) armed = 1'b1;
            cyc++;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            en[i] = 1'b0;
            n[i]  = 0;
        end
        run(3, 1'b1);
        run(2500, 1'b0);
        run(2, 1'b1);
        run(700, 1'b0);
        run(1, 1'b1);
        run(30000, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
